// File: rtl/param_sync_fifo_if.sv
// Handshake/status bundle for param_sync_fifo: producer/consumer side is the master,
// the FIFO itself is the slave.
interface param_sync_fifo_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic                  flush;
   logic                  wr_en;
   logic [WIDTH-1:0]      wr_data;
   logic                  rd_en;
   logic                  clr_err;
   logic [WIDTH-1:0]      rd_data;
   logic                  valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   level;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, wr_en, wr_data, rd_en, clr_err,
      input  rd_data, valid, full, empty, almost_full, almost_empty,
             level, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en, clr_err,
      output rd_data, valid, full, empty, almost_full, almost_empty,
             level, overflow, underflow
   );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock first-word-fall-through FIFO, any DEPTH >= 2, with thresholds, flush and
// sticky errors. Define FIFO_STATS_EN to add the high_water peak-occupancy port.
module param_sync_fifo #(
   parameter int WIDTH         = 32,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter int ADDR_WIDTH    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   param_sync_fifo_if.slave    bus
`ifdef FIFO_STATS_EN
   ,
   output logic [ADDR_WIDTH:0] high_water
`endif
);
   localparam int LEVEL_W = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [LEVEL_W-1:0]    FULL_LEVEL = LEVEL_W'(DEPTH);
   localparam logic [LEVEL_W-1:0]    AF_LEVEL   = LEVEL_W'(AFULL_THRESH);
   localparam logic [LEVEL_W-1:0]    AE_LEVEL   = LEVEL_W'(AEMPTY_THRESH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
   logic [LEVEL_W-1:0]    level_reg, level_next;
   logic                  overflow_reg, overflow_next;
   logic                  underflow_reg, underflow_next;
   logic                  full_w, empty_w, push, pop;

   // Explicit wrap so non-power-of-2 depths never index past the last entry.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full_w  = (level_reg == FULL_LEVEL);
      empty_w = (level_reg == '0);
      // A full FIFO still accepts a write when the same cycle pops.
      push    = !bus.flush && bus.wr_en && (!full_w || bus.rd_en);
      pop     = !bus.flush && bus.rd_en && !empty_w;

      wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
      rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
      level_next  = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase
      if (bus.flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         level_next  = '0;
      end

      // Set beats clear; flush suppresses both error sources.
      overflow_next  = (!bus.flush && bus.wr_en && full_w && !bus.rd_en)
                       || (overflow_reg && !bus.clr_err);
      underflow_next = (!bus.flush && bus.rd_en && empty_w)
                       || (underflow_reg && !bus.clr_err);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         level_reg     <= level_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   // Storage carries no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= bus.wr_data;
      end
   end

   assign bus.rd_data      = mem[rd_ptr_reg];
   assign bus.valid        = !empty_w;
   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.almost_full  = (level_reg >= AF_LEVEL);
   assign bus.almost_empty = (level_reg <= AE_LEVEL);
   assign bus.level        = level_reg;
   assign bus.overflow     = overflow_reg;
   assign bus.underflow    = underflow_reg;

`ifdef FIFO_STATS_EN
   logic [LEVEL_W-1:0] high_water_reg, high_water_next;

   always_comb begin
      high_water_next = high_water_reg;
      if (bus.clr_err) begin
         high_water_next = level_next;
      end else if (level_next > high_water_reg) begin
         high_water_next = level_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         high_water_reg <= '0;
      end else begin
         high_water_reg <= high_water_next;
      end
   end

   assign high_water = high_water_reg;
`endif
endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a 16x32 and a 5x8 instance, each checked every cycle
// against a queue model, plus directed scenarios with literal expectations.
module tb_param_sync_fifo;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          errors = 0;
   bit          run_cmp = 1'b0;
   logic        fl  [2];
   logic        wr  [2];
   logic        rd  [2];
   logic        clr [2];
   logic [31:0] wd  [2];

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      localparam int W  = (gi == 0) ? 32 : 8;
      localparam int D  = (gi == 0) ? 16 : 5;
      localparam int AF = (gi == 0) ? 14 : 4;
      localparam int AE = 2;

      param_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
      assign bus.flush   = fl[gi];
      assign bus.wr_en   = wr[gi];
      assign bus.rd_en   = rd[gi];
      assign bus.clr_err = clr[gi];
      assign bus.wr_data = wd[gi][W-1:0];
`ifdef FIFO_STATS_EN
      logic [$clog2(D):0] hw;
`endif

      param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
         .clk        (clk),
         .rst        (rst),
         .bus        (bus.slave)
`ifdef FIFO_STATS_EN
         ,
         .high_water (hw)
`endif
      );

      // Reference model: contents as a queue, errors and peak as plain variables.
      logic [31:0] mq [$];
      bit          m_ovf, m_unf, so, su;
      int          m_hw, lvl, n;

      always @(posedge clk or posedge rst) begin
         if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
            m_hw  = 0;
         end else begin
            lvl = mq.size();
            so  = 0;
            su  = 0;
            if (fl[gi]) begin
               mq.delete();
            end else begin
               so = wr[gi] && lvl == D && !rd[gi];
               su = rd[gi] && lvl == 0;
               if (rd[gi] && lvl > 0) void'(mq.pop_front());
               if (wr[gi] && (lvl < D || rd[gi])) mq.push_back(32'(wd[gi][W-1:0]));
            end
            m_ovf = so || (m_ovf && !clr[gi]);
            m_unf = su || (m_unf && !clr[gi]);
            if (clr[gi] || mq.size() > m_hw) m_hw = mq.size();
         end
      end

      always @(negedge clk) begin
         if (run_cmp && !rst) begin
            n = mq.size();
            chk($sformatf("i%0d.level", gi), bus.level, n);
            chk($sformatf("i%0d.full", gi), bus.full, n == D);
            chk($sformatf("i%0d.empty", gi), bus.empty, n == 0);
            chk($sformatf("i%0d.valid", gi), bus.valid, n > 0);
            chk($sformatf("i%0d.almost_full", gi), bus.almost_full, n >= AF);
            chk($sformatf("i%0d.almost_empty", gi), bus.almost_empty, n <= AE);
            chk($sformatf("i%0d.overflow", gi), bus.overflow, m_ovf);
            chk($sformatf("i%0d.underflow", gi), bus.underflow, m_unf);
            if (n > 0) chk($sformatf("i%0d.rd_data", gi), bus.rd_data, mq[0]);
`ifdef FIFO_STATS_EN
            chk($sformatf("i%0d.high_water", gi), hw, m_hw);
`endif
         end
      end
   end

   task automatic op(input int i, input bit f, input bit w, input bit r, input bit c,
                     input logic [31:0] d);
      fl[i] = f; wr[i] = w; rd[i] = r; clr[i] = c; wd[i] = d;
      @(posedge clk);
      #1;
      fl[i] = 0; wr[i] = 0; rd[i] = 0; clr[i] = 0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         fl[i] = 0; wr[i] = 0; rd[i] = 0; clr[i] = 0; wd[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      run_cmp = 1'b1;

      // Reset state
      chk("rst.level", g_fifo[0].bus.level, 0);
      chk("rst.empty", g_fifo[0].bus.empty, 1);
      chk("rst.valid", g_fifo[0].bus.valid, 0);
      chk("rst.almost_empty", g_fifo[0].bus.almost_empty, 1);
      chk("rst.almost_full", g_fifo[0].bus.almost_full, 0);

      // Fill to 16, then a refused 17th push
      for (int k = 0; k < 16; k++) begin
         op(0, 0, 1, 0, 0, 32'h11 + k);
         if (k == 12) chk("fill.af_at13", g_fifo[0].bus.almost_full, 0);
         if (k == 13) chk("fill.af_at14", g_fifo[0].bus.almost_full, 1);
      end
      chk("fill.level", g_fifo[0].bus.level, 16);
      chk("fill.full", g_fifo[0].bus.full, 1);
      op(0, 0, 1, 0, 0, 32'h99);
      chk("ovf.set", g_fifo[0].bus.overflow, 1);
      chk("ovf.level", g_fifo[0].bus.level, 16);

      // Simultaneous push/pop while full, then drain
      op(0, 0, 0, 0, 1, 32'h0);
      chk("clr.ovf", g_fifo[0].bus.overflow, 0);
      for (int k = 0; k < 3; k++) begin
         chk("fullrw.head", g_fifo[0].bus.rd_data, 32'h11 + k);
         op(0, 0, 1, 1, 0, 32'hAA);
         chk("fullrw.level", g_fifo[0].bus.level, 16);
         chk("fullrw.ovf", g_fifo[0].bus.overflow, 0);
      end
      for (int k = 0; k < 16; k++) begin
         chk("drain.head", g_fifo[0].bus.rd_data, (k < 13) ? 32'h14 + k : 32'hAA);
         op(0, 0, 0, 1, 0, 32'h0);
      end
      chk("drain.empty", g_fifo[0].bus.empty, 1);

      // Underflow, push+pop on empty, error clear
      op(0, 0, 0, 1, 0, 32'h0);
      chk("unf.set", g_fifo[0].bus.underflow, 1);
      chk("unf.level", g_fifo[0].bus.level, 0);
      op(0, 0, 1, 1, 0, 32'h55);
      chk("emptyrw.level", g_fifo[0].bus.level, 1);
      chk("emptyrw.data", g_fifo[0].bus.rd_data, 32'h55);
      op(0, 0, 0, 0, 1, 32'h0);
      chk("clr.unf", g_fifo[0].bus.underflow, 0);
      op(0, 0, 0, 1, 0, 32'h0);

      // Flush at level 7 with a concurrent write
      for (int k = 0; k < 7; k++) op(0, 0, 1, 0, 0, 32'h70 + k);
      chk("flush.pre", g_fifo[0].bus.level, 7);
      op(0, 1, 1, 0, 0, 32'h77);
      chk("flush.level", g_fifo[0].bus.level, 0);
      chk("flush.empty", g_fifo[0].bus.empty, 1);
      chk("flush.ovf", g_fifo[0].bus.overflow, 0);
      op(0, 0, 1, 0, 0, 32'h33);
      chk("flush.discard", g_fifo[0].bus.rd_data, 32'h33);
      op(0, 0, 0, 1, 0, 32'h0);

`ifdef FIFO_STATS_EN
      op(0, 0, 0, 0, 1, 32'h0);
      chk("hw.clr0", g_fifo[0].hw, 0);
      for (int k = 0; k < 9; k++) op(0, 0, 1, 0, 0, 32'h40 + k);
      for (int k = 0; k < 7; k++) op(0, 0, 0, 1, 0, 32'h0);
      chk("hw.peak", g_fifo[0].hw, 9);
      op(0, 0, 0, 0, 1, 32'h0);
      chk("hw.clr2", g_fifo[0].hw, 2);
      for (int k = 0; k < 2; k++) op(0, 0, 0, 1, 0, 32'h0);
`endif

      // DEPTH=5: interleaved pairs wrap the pointers, almost_full toggles at 4
      for (int k = 0; k < 3; k++) op(1, 0, 1, 0, 0, 32'h01 + k);
      for (int k = 0; k < 12; k++) begin
         op(1, 0, 1, 0, 0, 32'hA0 + k);
         chk("d5.af_on", g_fifo[1].bus.almost_full, 1);
         chk("d5.head", g_fifo[1].bus.rd_data, (k < 3) ? k + 1 : 32'hA0 + k - 3);
         op(1, 0, 0, 1, 0, 32'h0);
         chk("d5.af_off", g_fifo[1].bus.almost_full, 0);
      end
      for (int k = 0; k < 3; k++) op(1, 0, 0, 1, 0, 32'h0);

      // Random traffic on both instances with a mid-run async reset
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            for (int i = 0; i < 2; i++) begin
               fl[i] = 0; wr[i] = 0; rd[i] = 0; clr[i] = 0;
            end
            #1 rst = 1'b1;
            #1 rst = 1'b0;
            chk("arst.level0", g_fifo[0].bus.level, 0);
            chk("arst.empty1", g_fifo[1].bus.empty, 1);
         end
         for (int i = 0; i < 2; i++) begin
            fl[i]  = ($urandom_range(0, 63) == 0);
            wr[i]  = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 3) == 0);
            rd[i]  = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 3) != 0);
            clr[i] = ($urandom_range(0, 15) == 0);
            wd[i]  = $urandom;
         end
         @(posedge clk);
         #1;
      end

      run_cmp = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
